// File: rtl/flash_cfg_arb_pkg.sv
// flash_cfg_arb_pkg: FSM states, response codes and the forwarded command record for flash_cfg_arbiter
package flash_cfg_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;
  localparam logic [1:0] RESP_OK = 2'b00;
  localparam logic [1:0] RESP_ERR = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hFFFF_FFFF;
  typedef struct packed {
    logic [1:0] devsel;
    logic [13:0] addr;
    logic wren;
    logic rden;
    logic [31:0] wdata;
    logic expand_enable;
    logic expand_dir;
  } cmd_t;
endpackage

// File: rtl/flash_cfg_arb_timer.sv
// flash_cfg_arb_timer: counter cleared by load, advanced by en, tc high when count equals TERM (clk, rst, load, en in; tc out)
module flash_cfg_arb_timer #(
  parameter int W = 12,
  parameter int TERM = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  assign tc = cnt == W'(TERM);
endmodule

// File: rtl/flash_cfg_arbiter.sv
// flash_cfg_arbiter: round-robin A/B arbiter for the flash config port; ports: clock_tlx/reset, req{a,b}_* requester sides, flsh_* flash side, arb_status/arb_status_clr
module flash_cfg_arbiter
  import flash_cfg_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        clock_tlx,
  input  logic        reset,
  input  logic [1:0]  reqa_devsel,
  input  logic [13:0] reqa_addr,
  input  logic        reqa_wren,
  input  logic        reqa_rden,
  input  logic [31:0] reqa_wdata,
  input  logic        reqa_expand_enable,
  input  logic        reqa_expand_dir,
  output logic [31:0] reqa_rdata,
  output logic        reqa_done,
  output logic [1:0]  reqa_bresp,
  output logic [1:0]  reqa_rresp,
  input  logic [1:0]  reqb_devsel,
  input  logic [13:0] reqb_addr,
  input  logic        reqb_wren,
  input  logic        reqb_rden,
  input  logic [31:0] reqb_wdata,
  input  logic        reqb_expand_enable,
  input  logic        reqb_expand_dir,
  output logic [31:0] reqb_rdata,
  output logic        reqb_done,
  output logic [1:0]  reqb_bresp,
  output logic [1:0]  reqb_rresp,
  output logic [1:0]  flsh_devsel,
  output logic [13:0] flsh_addr,
  output logic        flsh_wren,
  output logic [31:0] flsh_wdata,
  output logic        flsh_rden,
  output logic        flsh_expand_enable,
  output logic        flsh_expand_dir,
  input  logic [31:0] flsh_rdata,
  input  logic        flsh_done,
  input  logic [1:0]  flsh_bresp,
  input  logic [1:0]  flsh_rresp,
  output logic [3:0]  arb_status,
  input  logic        arb_status_clr
);
  state_t state_q, state_d;
  cmd_t cmd_q, cmd_d, cmd_a, cmd_b, sel;
  logic ptr_q, ptr_d, owner_q, owner_d;
  logic sticky_to, sticky_ill, set_to, set_ill;
  logic grant, tc, cpl, pend_a, pend_b, pick_b;
  logic [31:0] cpl_rdata;
  logic [1:0] cpl_bresp, cpl_rresp;
  assign cmd_a = {reqa_devsel, reqa_addr, reqa_wren, reqa_rden, reqa_wdata, reqa_expand_enable, reqa_expand_dir};
  assign cmd_b = {reqb_devsel, reqb_addr, reqb_wren, reqb_rden, reqb_wdata, reqb_expand_enable, reqb_expand_dir};
  assign pend_a = reqa_wren || reqa_rden;
  assign pend_b = reqb_wren || reqb_rden;
  assign pick_b = pend_b && (!pend_a || ptr_q);
  assign sel = pick_b ? cmd_b : cmd_a;
  assign {flsh_devsel, flsh_addr, flsh_wren, flsh_rden, flsh_wdata, flsh_expand_enable, flsh_expand_dir} = cmd_q;
  assign arb_status = {sticky_ill, sticky_to, owner_q, state_q != IDLE};
  flash_cfg_arb_timer #(.W(CNT_W), .TERM(TIMEOUT_CYCLES - 1)) u_timer (
    .clk(clock_tlx),
    .rst(reset),
    .load(grant),
    .en(state_q == BUSY),
    .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    owner_d = owner_q;
    cmd_d = cmd_q;
    grant = 1'b0;
    cpl = 1'b0;
    cpl_rdata = '0;
    cpl_bresp = RESP_OK;
    cpl_rresp = RESP_OK;
    set_to = 1'b0;
    set_ill = 1'b0;
    case (state_q)
      IDLE: if (pend_a || pend_b) begin
        grant = 1'b1;
        owner_d = pick_b;
        ptr_d = !pick_b;
        if (sel.wren && sel.rden) begin
          cpl = 1'b1;
          cpl_bresp = RESP_ERR;
          cpl_rresp = RESP_ERR;
          set_ill = 1'b1;
          state_d = RELEASE;
        end else begin
          cmd_d = sel;
          state_d = BUSY;
        end
      end
      BUSY: if (flsh_done || tc) begin
        cpl = 1'b1;
        cpl_rdata = flsh_done ? flsh_rdata : TIMEOUT_RDATA;
        cpl_bresp = flsh_done ? flsh_bresp : RESP_ERR;
        cpl_rresp = flsh_done ? flsh_rresp : RESP_ERR;
        set_to = !flsh_done;
        cmd_d.wren = 1'b0;
        cmd_d.rden = 1'b0;
        state_d = RELEASE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock_tlx or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      owner_q <= 1'b0;
      cmd_q <= '0;
      sticky_to <= 1'b0;
      sticky_ill <= 1'b0;
      reqa_done <= 1'b0;
      reqb_done <= 1'b0;
      reqa_rdata <= '0;
      reqa_bresp <= '0;
      reqa_rresp <= '0;
      reqb_rdata <= '0;
      reqb_bresp <= '0;
      reqb_rresp <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      owner_q <= owner_d;
      cmd_q <= cmd_d;
      sticky_to <= set_to || (sticky_to && !arb_status_clr);
      sticky_ill <= set_ill || (sticky_ill && !arb_status_clr);
      reqa_done <= cpl && !owner_d;
      reqb_done <= cpl && owner_d;
      if (cpl && !owner_d) begin
        reqa_rdata <= cpl_rdata;
        reqa_bresp <= cpl_bresp;
        reqa_rresp <= cpl_rresp;
      end
      if (cpl && owner_d) begin
        reqb_rdata <= cpl_rdata;
        reqb_bresp <= cpl_bresp;
        reqb_rresp <= cpl_rresp;
      end
    end
endmodule

// File: tb/tb_flash_cfg_arbiter.sv
// tb_flash_cfg_arbiter: directed self-checking bench for flash_cfg_arbiter with a 16-cycle timeout
module tb_flash_cfg_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] reqa_devsel, reqb_devsel, flsh_devsel;
  logic [13:0] reqa_addr, reqb_addr, flsh_addr;
  logic reqa_wren, reqa_rden, reqb_wren, reqb_rden;
  logic [31:0] reqa_wdata, reqb_wdata, flsh_wdata;
  logic reqa_expand_enable, reqa_expand_dir, reqb_expand_enable, reqb_expand_dir;
  logic [31:0] reqa_rdata, reqb_rdata, flsh_rdata;
  logic reqa_done, reqb_done, flsh_done;
  logic [1:0] reqa_bresp, reqa_rresp, reqb_bresp, reqb_rresp, flsh_bresp, flsh_rresp;
  logic flsh_wren, flsh_rden, flsh_expand_enable, flsh_expand_dir;
  logic [3:0] arb_status;
  logic arb_status_clr;
  int passed = 0;
  int fails = 0;
  int total = 0;
  int na = 0;
  int nb = 0;
  flash_cfg_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock_tlx(clk), .reset(rst),
    .reqa_devsel(reqa_devsel), .reqa_addr(reqa_addr), .reqa_wren(reqa_wren), .reqa_rden(reqa_rden),
    .reqa_wdata(reqa_wdata), .reqa_expand_enable(reqa_expand_enable), .reqa_expand_dir(reqa_expand_dir),
    .reqa_rdata(reqa_rdata), .reqa_done(reqa_done), .reqa_bresp(reqa_bresp), .reqa_rresp(reqa_rresp),
    .reqb_devsel(reqb_devsel), .reqb_addr(reqb_addr), .reqb_wren(reqb_wren), .reqb_rden(reqb_rden),
    .reqb_wdata(reqb_wdata), .reqb_expand_enable(reqb_expand_enable), .reqb_expand_dir(reqb_expand_dir),
    .reqb_rdata(reqb_rdata), .reqb_done(reqb_done), .reqb_bresp(reqb_bresp), .reqb_rresp(reqb_rresp),
    .flsh_devsel(flsh_devsel), .flsh_addr(flsh_addr), .flsh_wren(flsh_wren), .flsh_wdata(flsh_wdata),
    .flsh_rden(flsh_rden), .flsh_expand_enable(flsh_expand_enable), .flsh_expand_dir(flsh_expand_dir),
    .flsh_rdata(flsh_rdata), .flsh_done(flsh_done), .flsh_bresp(flsh_bresp), .flsh_rresp(flsh_rresp),
    .arb_status(arb_status), .arb_status_clr(arb_status_clr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (reqa_done) na++;
    if (reqb_done) nb++;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    {reqa_devsel, reqa_addr, reqa_wren, reqa_rden, reqa_wdata, reqa_expand_enable, reqa_expand_dir} = '0;
    {reqb_devsel, reqb_addr, reqb_wren, reqb_rden, reqb_wdata, reqb_expand_enable, reqb_expand_dir} = '0;
    {flsh_rdata, flsh_done, flsh_bresp, flsh_rresp, arb_status_clr} = '0;
    step();
    step();
    chk("rst_flsh_rden", 32'(flsh_rden), 32'd0);
    chk("rst_flsh_wren", 32'(flsh_wren), 32'd0);
    chk("rst_flsh_addr", 32'(flsh_addr), 32'd0);
    chk("rst_done_a", 32'(reqa_done), 32'd0);
    chk("rst_done_b", 32'(reqb_done), 32'd0);
    chk("rst_status", 32'(arb_status), 32'd0);
    chk("rst_rdata_a", reqa_rdata, 32'd0);
    rst = 1'b0;
    reqa_rden = 1'b1;
    reqa_addr = 14'h0010;
    step();
    chk("t1_fwd_rden", 32'(flsh_rden), 32'd1);
    chk("t1_fwd_addr", 32'(flsh_addr), 32'h10);
    chk("t1_status", 32'(arb_status), 32'h1);
    repeat (3) step();
    flsh_done = 1'b1;
    flsh_rdata = 32'h1234_5678;
    step();
    flsh_done = 1'b0;
    chk("t1_done_a", 32'(reqa_done), 32'd1);
    chk("t1_rdata_a", reqa_rdata, 32'h1234_5678);
    chk("t1_rresp_a", 32'(reqa_rresp), 32'd0);
    chk("t1_drop_rden", 32'(flsh_rden), 32'd0);
    chk("t1_done_b", 32'(reqb_done), 32'd0);
    step();
    reqa_rden = 1'b0;
    chk("t1_done_a_once", 32'(reqa_done), 32'd0);
    chk("t1_no_regrant", 32'(flsh_rden), 32'd0);
    step();
    chk("t1_count_a", 32'(na), 32'd1);
    chk("t1_count_b", 32'(nb), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    reqa_wren = 1'b1;
    reqa_addr = 14'h0020;
    reqa_wdata = 32'hA5A5_0001;
    reqa_expand_enable = 1'b1;
    reqb_rden = 1'b1;
    reqb_addr = 14'h0030;
    step();
    chk("t2_a_wren", 32'(flsh_wren), 32'd1);
    chk("t2_a_rden", 32'(flsh_rden), 32'd0);
    chk("t2_a_addr", 32'(flsh_addr), 32'h20);
    chk("t2_a_wdata", flsh_wdata, 32'hA5A5_0001);
    chk("t2_a_expand", 32'(flsh_expand_enable), 32'd1);
    chk("t2_owner_a", 32'(arb_status[1]), 32'd0);
    flsh_done = 1'b1;
    step();
    flsh_done = 1'b0;
    chk("t2_done_a", 32'(reqa_done), 32'd1);
    chk("t2_bresp_a", 32'(reqa_bresp), 32'd0);
    chk("t2_done_b_idle", 32'(reqb_done), 32'd0);
    chk("t2_drop_wren", 32'(flsh_wren), 32'd0);
    reqa_addr = 14'h0021;
    step();
    chk("t2_gap_rden", 32'(flsh_rden), 32'd0);
    step();
    chk("t2_b_rden", 32'(flsh_rden), 32'd1);
    chk("t2_b_wren", 32'(flsh_wren), 32'd0);
    chk("t2_b_addr", 32'(flsh_addr), 32'h30);
    chk("t2_owner_b", 32'(arb_status[1]), 32'd1);
    flsh_done = 1'b1;
    flsh_rdata = 32'hBEEF_0002;
    step();
    flsh_done = 1'b0;
    chk("t2_done_b", 32'(reqb_done), 32'd1);
    chk("t2_rdata_b", reqb_rdata, 32'hBEEF_0002);
    chk("t2_a_waits", 32'(reqa_done), 32'd0);
    step();
    reqb_rden = 1'b0;
    step();
    chk("t2_a2_wren", 32'(flsh_wren), 32'd1);
    chk("t2_a2_addr", 32'(flsh_addr), 32'h21);
    chk("t2_a2_owner", 32'(arb_status[1]), 32'd0);
    flsh_done = 1'b1;
    step();
    flsh_done = 1'b0;
    chk("t2_a2_done", 32'(reqa_done), 32'd1);
    step();
    reqa_wren = 1'b0;
    reqa_expand_enable = 1'b0;
    step();
    reqa_wren = 1'b1;
    reqa_addr = 14'h0040;
    step();
    chk("t3_fwd_wren", 32'(flsh_wren), 32'd1);
    repeat (15) step();
    chk("t3_pre_done", 32'(reqa_done), 32'd0);
    chk("t3_pre_wren", 32'(flsh_wren), 32'd1);
    step();
    chk("t3_done", 32'(reqa_done), 32'd1);
    chk("t3_bresp", 32'(reqa_bresp), 32'h2);
    chk("t3_rdata", reqa_rdata, 32'hFFFF_FFFF);
    chk("t3_drop_wren", 32'(flsh_wren), 32'd0);
    chk("t3_sticky", 32'(arb_status[2]), 32'd1);
    step();
    reqa_wren = 1'b0;
    flsh_done = 1'b1;
    flsh_rdata = 32'h0BAD_0BAD;
    step();
    flsh_done = 1'b0;
    chk("t3_late_a", 32'(reqa_done), 32'd0);
    chk("t3_late_b", 32'(reqb_done), 32'd0);
    chk("t3_sticky_hold", 32'(arb_status[2]), 32'd1);
    arb_status_clr = 1'b1;
    step();
    arb_status_clr = 1'b0;
    chk("t3_clear", 32'(arb_status[2]), 32'd0);
    reqb_wren = 1'b1;
    reqb_rden = 1'b1;
    reqb_addr = 14'h0055;
    arb_status_clr = 1'b1;
    step();
    arb_status_clr = 1'b0;
    chk("t4_no_wren", 32'(flsh_wren), 32'd0);
    chk("t4_no_rden", 32'(flsh_rden), 32'd0);
    chk("t4_done_b", 32'(reqb_done), 32'd1);
    chk("t4_done_a", 32'(reqa_done), 32'd0);
    chk("t4_bresp", 32'(reqb_bresp), 32'h2);
    chk("t4_rresp", 32'(reqb_rresp), 32'h2);
    chk("t4_rdata", reqb_rdata, 32'd0);
    chk("t4_sticky_set_wins", 32'(arb_status[3]), 32'd1);
    step();
    reqb_wren = 1'b0;
    reqb_rden = 1'b0;
    chk("t4_done_once", 32'(reqb_done), 32'd0);
    step();
    reqa_rden = 1'b1;
    reqa_addr = 14'h0066;
    step();
    chk("t5_fwd_rden", 32'(flsh_rden), 32'd1);
    step();
    rst = 1'b1;
    #1;
    chk("t5_rst_rden", 32'(flsh_rden), 32'd0);
    chk("t5_rst_addr", 32'(flsh_addr), 32'd0);
    chk("t5_rst_status", 32'(arb_status), 32'd0);
    chk("t5_rst_done", 32'(reqa_done), 32'd0);
    chk("t5_rst_rdata", reqa_rdata, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("t5_regrant", 32'(flsh_rden), 32'd1);
    chk("t5_regrant_addr", 32'(flsh_addr), 32'h66);
    flsh_done = 1'b1;
    flsh_rdata = 32'hCAFE_0005;
    step();
    flsh_done = 1'b0;
    chk("t5_done", 32'(reqa_done), 32'd1);
    chk("t5_rdata", reqa_rdata, 32'hCAFE_0005);
    step();
    reqa_rden = 1'b0;
    step();
    reqb_rden = 1'b1;
    reqb_addr = 14'h0077;
    step();
    chk("t6_fwd_rden", 32'(flsh_rden), 32'd1);
    repeat (15) step();
    flsh_done = 1'b1;
    flsh_rdata = 32'h600D_0006;
    step();
    flsh_done = 1'b0;
    chk("t6_done", 32'(reqb_done), 32'd1);
    chk("t6_rresp", 32'(reqb_rresp), 32'd0);
    chk("t6_rdata", reqb_rdata, 32'h600D_0006);
    chk("t6_no_sticky", 32'(arb_status[2]), 32'd0);
    step();
    reqb_rden = 1'b0;
    step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
